// File: rtl/scan_chain_ctrl_pkg.sv
// Shared types and helpers for the scan chain load/capture/unload controller.
package scan_chain_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT_IN,
    ST_CAPTURE,
    ST_SHIFT_OUT,
    ST_DONE
  } state_t;

  // A 1-cell chain still needs a 1-bit counter.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/scan_shift_reg.sv
// Parallel-load shift register: left shift with serial fill, parallel out.
module scan_shift_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] din,
  input  logic         shift,
  input  logic         sin,
  output logic [W-1:0] q
);

  logic [W-1:0] q_shifted;

  generate
    if (W == 1) begin : g_one
      assign q_shifted = sin;
    end else begin : g_multi
      assign q_shifted = {q[W-2:0], sin};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst)        q <= '0;
    else if (load)  q <= din;
    else if (shift) q <= q_shifted;
  end

endmodule

// File: rtl/scan_chain_ctrl.sv
// Scan chain controller: serial pattern load, one capture cycle, serial response unload.
module scan_chain_ctrl
  import scan_chain_ctrl_pkg::*;
#(
  parameter int CHAIN_LEN = 8,
  localparam int CNT_W    = clog2_min1(CHAIN_LEN)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic [CHAIN_LEN-1:0] PAT_IN,
  input  logic                 SO,
  output logic                 SE,
  output logic                 SI,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [CHAIN_LEN-1:0] RESP_OUT
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [CHAIN_LEN-1:0] pat_q;
  logic                 unused_pat;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE:
          if (START) begin
            state <= ST_SHIFT_IN;
            cnt   <= CNT_LAST;
          end
        ST_SHIFT_IN:
          if (cnt == '0) state <= ST_CAPTURE;
          else           cnt   <= cnt - 1'b1;
        ST_CAPTURE: begin
          state <= ST_SHIFT_OUT;
          cnt   <= CNT_LAST;
        end
        ST_SHIFT_OUT:
          if (cnt == '0) state <= ST_DONE;
          else           cnt   <= cnt - 1'b1;
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // MSB goes out first so PAT_IN[k] finishes in cell k.
  scan_shift_reg #(.W(CHAIN_LEN)) u_pat (
    .clk   (CLK),
    .rst   (RST),
    .load  ((state == ST_IDLE) && START),
    .din   (PAT_IN),
    .shift (state == ST_SHIFT_IN),
    .sin   (1'b0),
    .q     (pat_q)
  );

  // Tail cell arrives first and is pushed up to RESP_OUT[CHAIN_LEN-1].
  scan_shift_reg #(.W(CHAIN_LEN)) u_resp (
    .clk   (CLK),
    .rst   (RST),
    .load  (1'b0),
    .din   ('0),
    .shift (state == ST_SHIFT_OUT),
    .sin   (SO),
    .q     (RESP_OUT)
  );

  assign unused_pat = ^pat_q;

  assign SE   = (state == ST_SHIFT_IN) || (state == ST_SHIFT_OUT);
  assign SI   = (state == ST_SHIFT_IN) && pat_q[CHAIN_LEN-1];
  assign BUSY = (state != ST_IDLE);
  assign DONE = (state == ST_DONE);

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl: behavioural scan chains whose capture inverts every cell.
module tb_scan_chain_ctrl;
  localparam int N    = 8;
  localparam int MAXC = 40;
  localparam int LAT  = 2 * N + 2;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic         RST = 1'b1, START = 1'b0, SO;
  logic [N-1:0] PAT_IN = '0;
  logic         SE, SI, BUSY, DONE;
  logic [N-1:0] RESP_OUT;

  logic         START1 = 1'b0, SO1;
  logic [0:0]   PAT1 = '0;
  logic         SE1, SI1, BUSY1, DONE1;
  logic [0:0]   RESP1;

  logic [N-1:0] chain  = '0;
  logic [0:0]   chain1 = '0;

  int checks = 0, failures = 0;

  logic         se_tr [0:MAXC];
  logic         si_tr [0:MAXC];
  logic         busy_tr [0:MAXC];
  int           done_cyc;
  logic [N-1:0] si_p, se_in_p, se_out_p, busy_p;

  scan_chain_ctrl #(.CHAIN_LEN(N)) dut (
    .CLK(CLK), .RST(RST), .START(START), .PAT_IN(PAT_IN), .SO(SO),
    .SE(SE), .SI(SI), .BUSY(BUSY), .DONE(DONE), .RESP_OUT(RESP_OUT)
  );

  scan_chain_ctrl #(.CHAIN_LEN(1)) dut1 (
    .CLK(CLK), .RST(RST), .START(START1), .PAT_IN(PAT1), .SO(SO1),
    .SE(SE1), .SI(SI1), .BUSY(BUSY1), .DONE(DONE1), .RESP_OUT(RESP1)
  );

  // Scan cells: shift when SE, otherwise capture D = ~Q.
  always @(posedge CLK) chain  <= SE  ? {chain[N-2:0], SI} : ~chain;
  always @(posedge CLK) chain1 <= SE1 ? SI1 : ~chain1;
  assign SO  = chain[N-1];
  assign SO1 = chain1[0];

  task automatic accept(input logic [N-1:0] pat);
    @(negedge CLK);
    PAT_IN = pat;
    START  = 1'b1;
  endtask

  // Records per-cycle outputs after the accepting edge; cycle k is the k-th cycle after it.
  task automatic trace(input bit hold, input bit poke);
    done_cyc = 0;
    for (int k = 1; k <= MAXC; k++) begin
      @(negedge CLK);
      se_tr[k] = SE; si_tr[k] = SI; busy_tr[k] = BUSY;
      if (!hold) begin
        START = poke && (k == 3 || k == 12);
        if (START) PAT_IN = N'($urandom);
      end
      if (DONE) begin done_cyc = k; break; end
    end
    for (int j = 0; j < N; j++) begin
      si_p[N-1-j]     = si_tr[j+1];
      se_in_p[N-1-j]  = se_tr[j+1];
      se_out_p[N-1-j] = se_tr[N+2+j];
      busy_p[N-1-j]   = busy_tr[j+1];
    end
  endtask

  task automatic test_reset;
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    checks++; if (SE !== 1'b0)   begin failures++; $display("FAIL reset_se got=%b exp=0", SE); end
    checks++; if (SI !== 1'b0)   begin failures++; $display("FAIL reset_si got=%b exp=0", SI); end
    checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", BUSY); end
    checks++; if (DONE !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", DONE); end
    checks++; if (RESP_OUT !== 8'h00) begin failures++; $display("FAIL reset_resp got=%h exp=00", RESP_OUT); end
    checks++; if (RESP1 !== 1'b0 || BUSY1 !== 1'b0) begin failures++; $display("FAIL reset_len1 got=%b%b exp=00", RESP1, BUSY1); end
    RST = 1'b0;
  endtask

  task automatic test_a5;
    logic [N-1:0] pat = 8'hA5;
    accept(pat);
    trace(1'b0, 1'b0);
    checks++; if (si_p !== pat)      begin failures++; $display("FAIL a5_si_seq got=%h exp=%h", si_p, pat); end
    checks++; if (se_in_p !== 8'hFF) begin failures++; $display("FAIL a5_se_shift_in got=%h exp=ff", se_in_p); end
    checks++; if (se_tr[N+1] !== 1'b0) begin failures++; $display("FAIL a5_se_capture got=%b exp=0", se_tr[N+1]); end
    checks++; if (se_out_p !== 8'hFF) begin failures++; $display("FAIL a5_se_shift_out got=%h exp=ff", se_out_p); end
    checks++; if (busy_p !== 8'hFF)  begin failures++; $display("FAIL a5_busy got=%h exp=ff", busy_p); end
    checks++; if (done_cyc != LAT)   begin failures++; $display("FAIL a5_latency got=%0d exp=%0d", done_cyc, LAT); end
    checks++; if (RESP_OUT !== ~pat) begin failures++; $display("FAIL a5_resp got=%h exp=%h", RESP_OUT, ~pat); end
    @(negedge CLK);
    checks++; if (DONE !== 1'b0 || BUSY !== 1'b0) begin failures++; $display("FAIL a5_done_pulse got=%b%b exp=00", DONE, BUSY); end
    checks++; if (RESP_OUT !== ~pat) begin failures++; $display("FAIL a5_resp_hold got=%h exp=%h", RESP_OUT, ~pat); end
  endtask

  task automatic test_start_ignored;
    logic [N-1:0] pat = 8'hA5;
    accept(pat);
    trace(1'b0, 1'b1);
    checks++; if (done_cyc != LAT)   begin failures++; $display("FAIL ign_latency got=%0d exp=%0d", done_cyc, LAT); end
    checks++; if (RESP_OUT !== ~pat) begin failures++; $display("FAIL ign_resp got=%h exp=%h", RESP_OUT, ~pat); end
  endtask

  task automatic test_back_to_back;
    accept(8'h00);
    trace(1'b1, 1'b0);
    checks++; if (done_cyc != LAT)    begin failures++; $display("FAIL b2b_first_latency got=%0d exp=%0d", done_cyc, LAT); end
    checks++; if (RESP_OUT !== 8'hFF) begin failures++; $display("FAIL b2b_first_resp got=%h exp=ff", RESP_OUT); end
    PAT_IN = 8'hFF;
    @(negedge CLK);
    checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL b2b_idle_gap got=%b exp=0", BUSY); end
    trace(1'b1, 1'b0);
    START = 1'b0;
    checks++; if (busy_tr[1] !== 1'b1) begin failures++; $display("FAIL b2b_second_accept got=%b exp=1", busy_tr[1]); end
    checks++; if (done_cyc != LAT)     begin failures++; $display("FAIL b2b_second_latency got=%0d exp=%0d", done_cyc, LAT); end
    checks++; if (RESP_OUT !== 8'h00)  begin failures++; $display("FAIL b2b_second_resp got=%h exp=00", RESP_OUT); end
  endtask

  task automatic test_random;
    for (int i = 0; i < 6; i++) begin
      logic [N-1:0] pat;
      pat = N'($urandom) & 8'hFE;
      accept(pat);
      trace(1'b0, 1'b0);
      checks++; if (si_p !== pat)      begin failures++; $display("FAIL rnd_si_seq[%0d] got=%h exp=%h", i, si_p, pat); end
      checks++; if (done_cyc != LAT)   begin failures++; $display("FAIL rnd_latency[%0d] got=%0d exp=%0d", i, done_cyc, LAT); end
      checks++; if (RESP_OUT !== ~pat) begin failures++; $display("FAIL rnd_resp[%0d] got=%h exp=%h", i, RESP_OUT, ~pat); end
      repeat ($urandom_range(0, 2)) @(negedge CLK);
    end
  endtask

  task automatic test_reset_mid;
    logic [N-1:0] pat;
    int ndone = 0;
    accept(8'h3C);
    for (int k = 1; k <= 5; k++) begin
      @(negedge CLK);
      START = 1'b0;
      if (k == 5) RST = 1'b1;
    end
    @(negedge CLK);
    RST = 1'b0;
    checks++; if (SE !== 1'b0 || BUSY !== 1'b0 || DONE !== 1'b0) begin
      failures++; $display("FAIL rstmid_ctrl got=%b%b%b exp=000", SE, BUSY, DONE); end
    checks++; if (RESP_OUT !== 8'h00) begin failures++; $display("FAIL rstmid_resp got=%h exp=00", RESP_OUT); end
    for (int k = 0; k < 25; k++) begin
      @(negedge CLK);
      if (DONE) ndone++;
    end
    checks++; if (ndone != 0) begin failures++; $display("FAIL rstmid_no_done got=%0d exp=0", ndone); end
    pat = N'($urandom);
    accept(pat);
    trace(1'b0, 1'b0);
    checks++; if (done_cyc != LAT)   begin failures++; $display("FAIL rstmid_rerun_latency got=%0d exp=%0d", done_cyc, LAT); end
    checks++; if (RESP_OUT !== ~pat) begin failures++; $display("FAIL rstmid_rerun_resp got=%h exp=%h", RESP_OUT, ~pat); end
  endtask

  task automatic test_len1;
    logic [3:0] se_seq = '0;
    logic       si_first = 1'b0;
    int         d1 = 0;
    @(negedge CLK);
    PAT1 = 1'b1; START1 = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge CLK);
      START1 = 1'b0;
      if (k <= 4) se_seq[4-k] = SE1;
      if (k == 1) si_first = SI1;
      if (DONE1) begin d1 = k; break; end
    end
    checks++; if (se_seq !== 4'b1010) begin failures++; $display("FAIL len1_se_seq got=%b exp=1010", se_seq); end
    checks++; if (si_first !== 1'b1)  begin failures++; $display("FAIL len1_si got=%b exp=1", si_first); end
    checks++; if (d1 != 4)            begin failures++; $display("FAIL len1_latency got=%0d exp=4", d1); end
    checks++; if (RESP1 !== ~PAT1)    begin failures++; $display("FAIL len1_resp got=%b exp=%b", RESP1, ~PAT1); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_a5();
    test_start_ignored();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_len1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
